// File: rtl/wb_write_queue.sv
// Writeback merge stage: ALU results go straight to the register-file port and load returns queue in a FIFO
// that drains on free cycles. Define WBQ_STATS_EN to add the saturating stallCount output.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             aluValid,
    input  logic [4:0]       aluRegister,
    input  logic [WIDTH-1:0] aluData,
    input  logic             ldValid,
    output logic             ldReady,
    input  logic [4:0]       ldRegister,
    input  logic [WIDTH-1:0] ldData,
    output logic             regWrite,
    output logic [4:0]       writeRegister,
    output logic [WIDTH-1:0] writeData,
    output logic [31:0]      busy
`ifdef WBQ_STATS_EN
    ,
    output logic [15:0]      stallCount
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [4:0] ZERO_REG = 5'd31;

    logic [4:0]       r_reg  [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic             w_alu_wr;
    logic             w_push;
    logic             w_pop;
    logic             w_head_live;
    logic [DEPTH-1:0] w_live_nxt;
    logic [31:0]      w_busy;

    // Load handshake: a load transfers on a cycle where ldValid && ldReady; ldValid must hold its
    // payload until then, and ldReady depends only on registered occupancy, never on ldValid.
    assign ldReady     = (r_count < FULL);
    assign w_alu_wr    = aluValid && (aluRegister != ZERO_REG);
    // Loads to the zero register complete the handshake but never occupy a slot.
    assign w_push      = ldValid && ldReady && (ldRegister != ZERO_REG);
    assign w_pop       = !w_alu_wr && (r_count != '0);
    assign w_head_live = r_live[r_rptr];

    always_comb begin
        w_live_nxt = r_live;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alu_wr && (r_reg[i] == aluRegister)) begin
                w_live_nxt[i] = 1'b0;
            end
        end
        if (w_pop) begin
            w_live_nxt[r_rptr] = 1'b0;
        end
        // Applied last: a load arriving alongside the ALU write is younger and survives.
        if (w_push) begin
            w_live_nxt[r_wptr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg[r_wptr]  <= ldRegister;
            r_data[r_wptr] <= ldData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_live <= w_live_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else if (w_alu_wr) begin
            regWrite      <= 1'b1;
            writeRegister <= aluRegister;
            writeData     <= aluData;
        end else if (w_pop && w_head_live) begin
            regWrite      <= 1'b1;
            writeRegister <= r_reg[r_rptr];
            writeData     <= r_data[r_rptr];
        end else begin
            regWrite      <= 1'b0;
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i]) begin
                w_busy[r_reg[i]] = 1'b1;
            end
        end
        if (regWrite) begin
            w_busy[writeRegister] = 1'b1;
        end
        w_busy[31] = 1'b0;
    end

    assign busy = w_busy;

`ifdef WBQ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCount <= '0;
        end else if (ldValid && !ldReady && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed vector table, hand-built full/reset sequences, then random
// traffic against a queue-based model of the writeback rules.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             aluValid;
    logic [4:0]       aluRegister;
    logic [WIDTH-1:0] aluData;
    logic             ldValid;
    logic             ldReady;
    logic [4:0]       ldRegister;
    logic [WIDTH-1:0] ldData;
    logic             regWrite;
    logic [4:0]       writeRegister;
    logic [WIDTH-1:0] writeData;
    logic [31:0]      busy;
`ifdef WBQ_STATS_EN
    logic [15:0]      stallCount;
`endif

    wb_write_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .aluValid      (aluValid),
        .aluRegister   (aluRegister),
        .aluData       (aluData),
        .ldValid       (ldValid),
        .ldReady       (ldReady),
        .ldRegister    (ldRegister),
        .ldData        (ldData),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .busy          (busy)
`ifdef WBQ_STATS_EN
        ,
        .stallCount    (stallCount)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [63:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [63:0] ld;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [63:0] d;
        bit          live;
    } ent_t;

    // reference model state
    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    logic [15:0] m_stall;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        foreach (mq[k]) if (mq[k].live) b[mq[k].r] = 1'b1;
        if (m_we) b[m_wa] = 1'b1;
        b[31] = 1'b0;
        return b;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        m_stall = '0;
    endtask

    // Applies one cycle of inputs; entered and left at posedge+1.
    task automatic step(input vec_t v, input bit has_exp);
        bit   acc;
        ent_t e;
        aluValid    = v.av;
        aluRegister = v.ar;
        aluData     = v.ad;
        ldValid     = v.lv;
        ldRegister  = v.lr;
        ldData      = v.ld;
        #1;
        chk("ready", {63'd0, ldReady}, {63'd0, (mq.size() < DEPTH)});
        chk("busy_pre", {32'd0, busy}, {32'd0, m_busy()});
        if (has_exp) chk("vec_ready", {63'd0, ldReady}, {63'd0, v.e_rdy});

        acc = v.lv && (mq.size() < DEPTH);
        if (v.lv && !acc && m_stall != 16'hFFFF) m_stall++;
        if (v.av && v.ar != 5'd31) begin
            foreach (mq[k]) if (mq[k].r == v.ar) mq[k].live = 1'b0;
            m_we = 1'b1;
            m_wa = v.ar;
            m_wd = v.ad;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = e.live;
            if (e.live) begin
                m_wa = e.r;
                m_wd = e.d;
            end
        end else begin
            m_we = 1'b0;
        end
        if (acc && v.lr != 5'd31) mq.push_back('{r: v.lr, d: v.ld, live: 1'b1});

        @(posedge clk);
        #1;
        chk("regWrite", {63'd0, regWrite}, {63'd0, m_we});
        chk("writeRegister", {59'd0, writeRegister}, {59'd0, m_wa});
        chk("writeData", writeData, m_wd);
        chk("busy", {32'd0, busy}, {32'd0, m_busy()});
`ifdef WBQ_STATS_EN
        chk("stallCount", {48'd0, stallCount}, {48'd0, m_stall});
`endif
        if (has_exp) begin
            chk("vec_we", {63'd0, regWrite}, {63'd0, v.e_we});
            chk("vec_wa", {59'd0, writeRegister}, {59'd0, v.e_wa});
            chk("vec_wd", writeData, v.e_wd);
            chk("vec_busy", {32'd0, busy}, {32'd0, v.e_busy});
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                                input logic lv, input logic [4:0] lr, input logic [63:0] ld);
        vec_t v;
        v = '{av: av, ar: ar, ad: ad, lv: lv, lr: lr, ld: ld,
              e_rdy: 1'b1, e_we: 1'b0, e_wa: '0, e_wd: '0, e_busy: '0};
        return v;
    endfunction

    vec_t vecs[16];

    initial begin
        vec_t v;
        logic [4:0] rr;

        vecs[0]  = '{1'b1, 5'd5,  64'hDEAD_BEEF, 1'b0, 5'd0,  64'h0,  1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 32'h20};
        vecs[1]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 5'd5, 64'hDEAD_BEEF, 32'h0};
        vecs[2]  = '{1'b0, 5'd0,  64'h0,         1'b1, 5'd3,  64'h11, 1'b1, 1'b0, 5'd5, 64'hDEAD_BEEF, 32'h8};
        vecs[3]  = '{1'b1, 5'd1,  64'h100,       1'b0, 5'd0,  64'h0,  1'b1, 1'b1, 5'd1, 64'h100,       32'hA};
        vecs[4]  = '{1'b1, 5'd2,  64'h200,       1'b0, 5'd0,  64'h0,  1'b1, 1'b1, 5'd2, 64'h200,       32'hC};
        vecs[5]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,  1'b1, 1'b1, 5'd3, 64'h11,        32'h8};
        vecs[6]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 5'd3, 64'h11,        32'h0};
        vecs[7]  = '{1'b0, 5'd0,  64'h0,         1'b1, 5'd7,  64'hAA, 1'b1, 1'b0, 5'd3, 64'h11,        32'h80};
        vecs[8]  = '{1'b1, 5'd7,  64'hBB,        1'b0, 5'd0,  64'h0,  1'b1, 1'b1, 5'd7, 64'hBB,        32'h80};
        vecs[9]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 5'd7, 64'hBB,        32'h0};
        vecs[10] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 5'd7, 64'hBB,        32'h0};
        vecs[11] = '{1'b1, 5'd31, 64'h55,        1'b1, 5'd31, 64'h66, 1'b1, 1'b0, 5'd7, 64'hBB,        32'h0};
        vecs[12] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 5'd7, 64'hBB,        32'h0};
        vecs[13] = '{1'b1, 5'd9,  64'h9,         1'b1, 5'd9,  64'h99, 1'b1, 1'b1, 5'd9, 64'h9,         32'h200};
        vecs[14] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,  1'b1, 1'b1, 5'd9, 64'h99,        32'h200};
        vecs[15] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 5'd9, 64'h99,        32'h0};

        reset = 1'b0;
        aluValid = 1'b0; aluRegister = '0; aluData = '0;
        ldValid = 1'b0;  ldRegister = '0;  ldData = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_regWrite", {63'd0, regWrite}, 64'd0);
        chk("rst_writeRegister", {59'd0, writeRegister}, 64'd0);
        chk("rst_writeData", writeData, 64'd0);
        chk("rst_busy", {32'd0, busy}, 64'd0);
        chk("rst_ldReady", {63'd0, ldReady}, 64'd1);
        reset = 1'b1;

        // directed table: ALU path, load behind ALU, squash, zero register, same-cycle push
        for (int i = 0; i < 16; i++) step(vecs[i], 1'b1);

        // full FIFO with ALU busy every cycle, then a held fifth load
        for (int i = 0; i < 4; i++) step(mk(1'b1, 5'd1, 64'(i), 1'b1, 5'(10 + i), 64'h1000 + 64'(i)), 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(mk(1'b1, 5'd1, 64'h77, 1'b1, 5'd14, 64'h1004), 1'b0);
            chk("full_ldReady", {63'd0, ldReady}, 64'd0);
        end
        exp_q = '{64'h1000, 64'h1001, 64'h1002, 64'h1003, 64'h1004};
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (i < 2) step(mk(1'b0, 5'd0, 64'h0, 1'b1, 5'd14, 64'h1004), 1'b0);
            else       step(mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0), 1'b0);
            if (regWrite) got_q.push_back(writeData);
        end
        chk("drain_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) chk("drain_order", got_q.pop_front(), exp_q.pop_front());
`ifdef WBQ_STATS_EN
        chk("full_stallCount", {48'd0, stallCount}, 64'd3);
`endif

        // reset pulled mid-drain while the output register holds a write
        for (int i = 0; i < 3; i++) step(mk(1'b1, 5'd2, 64'h5 + 64'(i), 1'b1, 5'(20 + i), 64'h2000 + 64'(i)), 1'b0);
        aluValid = 1'b0; ldValid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_regWrite", {63'd0, regWrite}, 64'd0);
        chk("midrst_busy", {32'd0, busy}, 64'd0);
        chk("midrst_ldReady", {63'd0, ldReady}, 64'd1);
        m_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 5; i++) step(mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0), 1'b0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            v = mk(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
            v.av = ($urandom_range(0, 99) < 45);
            rr = 5'($urandom_range(0, 8));
            v.ar = (rr == 5'd8) ? 5'd31 : rr;
            v.ad = {$urandom, $urandom};
            v.lv = ($urandom_range(0, 99) < 55);
            rr = 5'($urandom_range(0, 8));
            v.lr = (rr == 5'd8) ? 5'd31 : rr;
            v.ld = {$urandom, $urandom};
            step(v, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Writeback stage directly upstream of the 32×64 register file. Merges two result sources, the single-cycle ALU path and the variable-latency load-return path, onto the register file's single write port (`regWrite`, `writeRegister`, `writeData`). ALU results are written immediately. Load results wait in a small FIFO and drain on cycles the ALU leaves the port free. A per-register busy mask lets decode stall on pending writes.

## Interface
- `DEPTH`, default 4: load FIFO entries; power of two, ≥2.
- `WIDTH`, default 64: data width; matches the register file.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `aluValid` in 1: ALU result valid this cycle; no backpressure, always accepted.
- `aluRegister` in 5: ALU destination register.
- `aluData` in WIDTH: ALU result.
- `ldValid` in 1: load-return valid.
- `ldReady` out 1: load-return accepted when `ldValid && ldReady`.
- `ldRegister` in 5: load destination register.
- `ldData` in WIDTH: load data.
- `regWrite` out 1: write enable to the register file; registered.
- `writeRegister` out 5: write address; registered.
- `writeData` out WIDTH: write data; registered.
- `busy` out 32: bit r=1 while a write to r is queued or in the output register.

## Operation
- Reset values:
  - `regWrite`=0, `writeRegister`=0, `writeData`=0.
  - FIFO empty (count=0, pointers 0, all entry-live bits 0).
  - `busy`=0, `ldReady`=1.
- Each cycle, exactly one of three actions loads the output register:
  1. `aluValid && aluRegister!=31`: output ← ALU write, `regWrite`=1.
  2. Otherwise, if the FIFO head is live: output ← head, `regWrite`=1, head popped.
  3. Otherwise: `regWrite`=0. Address and data hold their previous values.
- Dead head entries are popped without writing. The pop takes the cycle and the output is `regWrite`=0.
- Writes to register 31 are dropped (it is the zero register): ALU writes are ignored and loads to 31 are accepted and discarded.
- `ldReady` = (count < DEPTH), derived from registered count only. A same-cycle pop does not free a slot for a same-cycle push.
- An accepted load is pushed at the tail with its live bit set.
- Squash rule:
  - An accepted ALU write to r clears the live bit of every FIFO entry targeting r. The ALU write is younger in program order.
  - A load to r pushed in the same cycle as the ALU write to r is NOT squashed.
- `busy[r]` = OR of (live entries with reg r) | (`regWrite && writeRegister==r`). `busy[31]` is always 0. Combinational from registered state.
- Arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits: +1 on push, −1 on pop, unchanged on push+pop.

## Timing
- ALU result at edge N → `regWrite`/`writeRegister`/`writeData` valid from edge N+1 for one cycle. The register file commits at edge N+2.
- Load accepted at edge N, FIFO previously empty, no ALU write at N+1 → output from edge N+2. Minimum load latency is 2 cycles.
- Each consecutive `aluValid` cycle delays the FIFO drain by one cycle. Starvation is permitted; upstream guarantees ALU gaps.
- Full FIFO: `ldReady`=0 until a pop completes. `ldReady` returns to 1 the cycle after the pop edge.
- Reset asserted mid-operation: all queued writes are discarded immediately. `regWrite` drops to 0 asynchronously.

## Configuration
- `WBQ_STATS_EN` defined:
  - Adds output `stallCount` (16 bits), reset 0.
  - Increments each cycle `ldValid && !ldReady`, saturating at 16'hFFFF.
- Undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- ALU-only: `aluValid`=1, reg 5, data 64'hDEAD_BEEF at edge 0 → edge 1 `regWrite`=1, `writeRegister`=5, `writeData`=64'hDEAD_BEEF; edge 2 `regWrite`=0.
- Load drain behind ALU: load reg 3 = 64'h11 at edge 0, ALU writes at edges 1 and 2 → load appears on the port at edge 4; `busy[3]`=1 from edge 1 through edge 4.
- Full/backpressure (DEPTH=4): 4 loads with ALU busy every cycle → `ldReady`=0; a 5th `ldValid` is held; once ALU idles, all 5 drain in order; `stallCount` counts the held cycles (with `WBQ_STATS_EN`).
- Squash: load reg 7 = 64'hAA queued, then ALU writes reg 7 = 64'hBB → only 64'hBB is written to 7; the dead entry is popped with `regWrite`=0; `busy[7]` clears after the ALU write leaves the output.
- Zero register: ALU and load writes to 31 → `regWrite` never asserts for them; the load is still accepted; `busy[31]`=0.
- Reset mid-drain: 3 loads queued, `reset` pulled low between edges → `regWrite`=0 immediately; `busy`=0; `ldReady`=1; nothing is written after release.
